// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the Booth multiplier controller: FSM states and
// radix-2 recode operations.
package mult_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_ctrl_recode.sv
// Combinational radix-2 Booth recode: selects adder operand B / carry-in and
// derives the true sign of the step result for the arithmetic shift.
module booth_recode #(
  parameter int WIDTH = 32
) (
  input  logic             q0,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  output logic             sign
);
  import mult_pkg::*;

  logic v;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (booth_decode(q0, q_m1))
      BOOTH_ADD: add_b = m;
      BOOTH_SUB: begin
        add_b   = ~m;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  // The adder is only 32 bits wide; recover the 33rd (sign) bit from
  // signed overflow instead of the carry-out.
  assign v    = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
  assign sign = add_sum[WIDTH-1] ^ v;

endmodule

// File: rtl/booth_mult_ctrl.sv
// Multi-cycle signed multiplier controller sequencing an external 32-bit adder
// through 32 radix-2 Booth steps.
module booth_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             result_valid
);
  import mult_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] m_q, a_q, q_q;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_raw;
  logic             cin_raw;
  logic             sign;
  logic [WIDTH-1:0] a_nxt, q_nxt;
  logic             running;

  booth_recode #(.WIDTH(WIDTH)) u_recode (
    .q0      (q_q[0]),
    .q_m1    (q_m1),
    .m       (m_q),
    .add_a   (a_q),
    .add_sum (add_sum),
    .add_b   (b_raw),
    .add_cin (cin_raw),
    .sign    (sign)
  );

  assign running = (state == RUN);
  assign add_a   = running ? a_q   : '0;
  assign add_b   = running ? b_raw : '0;
  assign add_cin = running & cin_raw;

  assign a_nxt = {sign, add_sum[WIDTH-1:1]};
  assign q_nxt = {add_sum[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      m_q          <= '0;
      a_q          <= '0;
      q_q          <= '0;
      q_m1         <= 1'b0;
      cnt          <= '0;
      ready        <= 1'b1;
      result_lo    <= '0;
      result_hi    <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            m_q   <= op_a;
            a_q   <= '0;
            q_q   <= op_b;
            q_m1  <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          a_q  <= a_nxt;
          q_q  <= q_nxt;
          q_m1 <= q_q[0];
          cnt  <= cnt + CNT_W'(1);
          // Results are taken from the final step's shifted value so they
          // are visible in the DONE cycle itself.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result_hi    <= a_nxt;
            result_lo    <= q_nxt;
            overflow     <= !((&{a_nxt, q_nxt[WIDTH-1]}) || !(|{a_nxt, q_nxt[WIDTH-1]}));
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
- Multi-cycle signed 32x32 multiplier controller using radix-2 Booth recoding.
- Owns no adder. It sequences the team's existing 32-bit carry-lookahead adder through an operand/sum loop: one add, subtract or pass per cycle, for 32 cycles.
- Sits beside the ALU in the execute stage. The pipeline issues `mult` ops with a start/ready handshake and waits for a one-cycle result_valid.

Parameters:
- WIDTH, 32, operand width; only 32 is supported and verified.
- CNT_W, 6, step-counter width; must hold values 0..WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  1 in IDLE
- op_a  in  32  multiplicand M, two's complement, sampled on accept
- op_b  in  32  multiplier Q, two's complement, sampled on accept
- add_a  out  32  adder operand A (accumulator high half)
- add_b  out  32  adder operand B: M, ~M, or 0
- add_cin  out  1  1 only for subtract
- add_sum  in  32  combinational sum returned by the external CLA adder, same cycle
- result_lo  out  32  product bits [31:0]
- result_hi  out  32  product bits [63:32]
- overflow  out  1  product not representable in 32 signed bits
- result_valid  out  1  one-cycle pulse when results are final

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, all product registers 0.
  - ready=1, result_lo/hi=0, overflow=0, result_valid=0.
  - add_a/add_b/add_cin=0.
  - Any in-flight operation is discarded, with no valid pulse.
- Registers:
  - M[31:0].
  - Product P = {A[31:0], Q[31:0], q_m1}.
  - Step counter.
- States:
  - IDLE: ready=1. On start: M<=op_a, A<=0, Q<=op_b, q_m1<=0, counter<=0, go to RUN.
  - RUN: ready=0. One Booth step per cycle. After the step where counter==31 completes, go to DONE.
  - DONE: result_valid=1 for exactly this cycle. Outputs update at the DONE entry edge. Next state IDLE.
- Booth step in RUN, keyed on {Q[0], q_m1}:
  - 00/11: add_b=0, add_cin=0.
  - 01: add_b=M, add_cin=0.
  - 10: add_b=~M, add_cin=1.
  - add_a=A in all cases.
  - Then arithmetic right shift: A<={s, add_sum[31:1]}, Q<={add_sum[0], Q[31:1]}, q_m1<=Q[0].
- Sign bit s, for the 32-bit adder overflow case (e.g. M=-2^31):
  - v = (add_a[31]==add_b[31]) && (add_sum[31]!=add_a[31]).
  - s = add_sum[31] ^ v.
  - The controller must not rely on the adder's carry-out.
- Latency:
  - start accepted at edge 0; result_valid is high in the cycle after edge 32.
  - ready returns at edge 33.
  - 34 cycles from start high to next possible accept.
- Outputs:
  - result_hi=A, result_lo=Q, latched into output registers at DONE entry.
  - overflow=1 unless bits [63:31] of the product are all equal.
  - All three hold their value until the next DONE; they do not change during RUN.
- start while ready=0 is ignored, and the operands are not sampled. The requester must hold start until it sees ready.
- start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- add_a/add_b/add_cin are 0 outside RUN, so the shared adder sees quiet inputs.
- op_a/op_b may change freely after accept.

Decomposition:
- Shared package `mult_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 recovers to IDLE.
  - WIDTH.
  - Booth recode constants: BOOTH_NOP, BOOTH_ADD, BOOTH_SUB.
- One natural sub-module: `booth_recode`, a combinational map of {Q[0], q_m1} to add_b/add_cin plus the shift sign-fix.
- The FSM, counter and product registers stay in the top module.
- The adder is instantiated by the parent, not inside this block.

Test Plan:
- Small positives: op_a=3, op_b=5, start -> after 33 edges result_valid=1, result_lo=15, result_hi=0, overflow=0; ready back high next cycle.
- Mixed signs: op_a=-7, op_b=6 -> result_lo=0xFFFFFFD6, result_hi=0xFFFFFFFF, overflow=0.
- Positive overflow: op_a=0x7FFFFFFF, op_b=2 -> result_lo=0xFFFFFFFE, result_hi=0, overflow=1.
- Sign-fix corner 1: op_a=0x80000000, op_b=0xFFFFFFFF -> result_lo=0x80000000, result_hi=0, overflow=1.
- Sign-fix corner 2: op_a=op_b=0x80000000 -> result_hi=0x40000000, result_lo=0, overflow=1.
- Busy and reset:
  - Start 3*5, pulse start with 9*9 at cycle 10 -> ignored; the result is 15.
  - Then start a new op and drop reset_n at cycle 12 -> immediately ready=1, add_* = 0, no result_valid.
  - The next 4*4 returns 16.
